// File: rtl/prt_rx_ingress.sv
// MAC-to-PRT ingress: slot admission at sof, 2-stage byte pipeline, length/error
// qualification at stop and accepted/dropped frame statistics.
module prt_rx_ingress #(
  parameter  int DATA_WIDTH = 8,
  parameter  int MIN_FRAME  = 64,
  parameter  int MAX_FRAME  = 1518,
  parameter  int CNT_WIDTH  = 16,
  localparam int LEN_W      = $clog2(MAX_FRAME + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_sof,
  input  logic                  rx_eof,
  input  logic                  rx_err,
  input  logic                  prt_slot_available,
  output logic                  prt_start_receive,
  output logic                  prt_frame_in_valid,
  output logic [DATA_WIDTH-1:0] prt_frame_data_in,
  output logic                  prt_stop_receive,
  output logic                  prt_frame_bad,
  output logic [LEN_W-1:0]      prt_frame_len,
  output logic [CNT_WIDTH-1:0]  frames_accepted,
  output logic [CNT_WIDTH-1:0]  frames_dropped
);

  typedef enum logic [2:0] {IDLE, START, RECV, STOP, DROP, DROP_REST} state_t;

  state_t                  state_reg;
  state_t                  after_reg;
  logic                    s1_valid_reg, s1_eof_reg, s1_err_reg;
  logic [DATA_WIDTH-1:0]   s1_data_reg;
  logic                    s2_valid_reg, s2_eof_reg, s2_err_reg;
  logic [DATA_WIDTH-1:0]   s2_data_reg;
  logic [LEN_W-1:0]        len_reg;
  logic                    bad_reg;
  logic                    rx_open_reg;
  logic                    start_reg, stop_reg, frame_bad_reg;
  logic [LEN_W-1:0]        frame_len_reg;
  logic [CNT_WIDTH-1:0]    accepted_reg, dropped_reg;

  logic             rx_sof_v, rx_eof_v, in_recv, at_max;
  logic             emit, overflow, abort, last, close_frame, bad_fin, drop_new;
  logic [LEN_W-1:0] len_fin;

  assign rx_sof_v    = rx_valid & rx_sof;
  assign rx_eof_v    = rx_valid & rx_eof;
  assign in_recv     = (state_reg == RECV);
  assign at_max      = (len_reg == LEN_W'(MAX_FRAME));
  assign emit        = in_recv & s2_valid_reg & ~at_max;
  assign overflow    = in_recv & s2_valid_reg & at_max;
  // A new sof before the current frame's eof aborts the open frame.
  assign abort       = (in_recv | (state_reg == START)) & rx_sof_v;
  assign last        = emit & s2_eof_reg;
  assign close_frame = last | overflow | abort;
  assign len_fin     = len_reg + LEN_W'(emit);
  assign bad_fin     = bad_reg | (emit & s2_err_reg) | overflow | (abort & ~last)
                     | (len_fin < LEN_W'(MIN_FRAME));
  assign drop_new    = rx_sof_v | (after_reg == DROP);

  // Two fixed delay stages; the PRT sees each MAC byte exactly two cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_eof_reg   <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_data_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_eof_reg   <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rx_valid;
      s1_eof_reg   <= rx_eof;
      s1_err_reg   <= rx_err;
      s1_data_reg  <= rx_data;
      s2_valid_reg <= s1_valid_reg;
      s2_eof_reg   <= s1_eof_reg;
      s2_err_reg   <= s1_err_reg;
      s2_data_reg  <= s1_data_reg;
    end
  end

  // Tracks whether the MAC side is still inside a frame, so discard states end
  // correctly even when the eof already passed into the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_open_reg <= 1'b0;
    end else if (rx_sof_v) begin
      rx_open_reg <= ~rx_eof;
    end else if (rx_eof_v) begin
      rx_open_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      after_reg     <= IDLE;
      len_reg       <= '0;
      bad_reg       <= 1'b0;
      start_reg     <= 1'b0;
      stop_reg      <= 1'b0;
      frame_bad_reg <= 1'b0;
      frame_len_reg <= '0;
      accepted_reg  <= '0;
      dropped_reg   <= '0;
    end else begin
      start_reg     <= 1'b0;
      stop_reg      <= 1'b0;
      frame_bad_reg <= 1'b0;
      frame_len_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (rx_sof_v) begin
            if (prt_slot_available && !rx_eof) begin
              state_reg <= START;
              start_reg <= 1'b1;
              len_reg   <= '0;
              bad_reg   <= 1'b0;
            end else begin
              state_reg   <= DROP;
              dropped_reg <= dropped_reg + 1'b1;
            end
          end
        end
        START, RECV: begin
          len_reg <= len_fin;
          bad_reg <= bad_reg | (emit & s2_err_reg);
          if (close_frame) begin
            state_reg     <= STOP;
            stop_reg      <= 1'b1;
            frame_len_reg <= len_fin;
            frame_bad_reg <= bad_fin;
            after_reg     <= abort ? DROP : (overflow ? DROP_REST : IDLE);
          end else if (state_reg == START) begin
            state_reg <= RECV;
          end
        end
        STOP: begin
          dropped_reg  <= dropped_reg + CNT_WIDTH'(frame_bad_reg) + CNT_WIDTH'(drop_new);
          accepted_reg <= accepted_reg + CNT_WIDTH'(!frame_bad_reg);
          state_reg    <= drop_new ? DROP : after_reg;
        end
        DROP, DROP_REST: begin
          if (rx_eof_v || !rx_open_reg) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign prt_start_receive  = start_reg;
  assign prt_frame_in_valid = emit;
  assign prt_frame_data_in  = s2_data_reg;
  assign prt_stop_receive   = stop_reg;
  assign prt_frame_bad      = frame_bad_reg;
  assign prt_frame_len      = frame_len_reg;
  assign frames_accepted    = accepted_reg;
  assign frames_dropped     = dropped_reg;

endmodule

// File: tb/tb_prt_rx_ingress.sv
// Directed + randomized frames for prt_rx_ingress, checked against a per-frame
// reference model of expected PRT transactions, timing and statistics.
module tb_prt_rx_ingress;
  localparam int DW   = 8;
  localparam int MINF = 64;
  localparam int MAXF = 1518;
  localparam int CW   = 16;
  localparam int LW   = $clog2(MAXF + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid, rx_sof, rx_eof, rx_err, prt_slot_available;
  logic [DW-1:0] rx_data;
  logic          prt_start_receive, prt_frame_in_valid, prt_stop_receive, prt_frame_bad;
  logic [DW-1:0] prt_frame_data_in;
  logic [LW-1:0] prt_frame_len;
  logic [CW-1:0] frames_accepted, frames_dropped;

  prt_rx_ingress #(.DATA_WIDTH(DW), .MIN_FRAME(MINF), .MAX_FRAME(MAXF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
    .prt_slot_available(prt_slot_available),
    .prt_start_receive(prt_start_receive), .prt_frame_in_valid(prt_frame_in_valid),
    .prt_frame_data_in(prt_frame_data_in), .prt_stop_receive(prt_stop_receive),
    .prt_frame_bad(prt_frame_bad), .prt_frame_len(prt_frame_len),
    .frames_accepted(frames_accepted), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  int cycle_count = 0;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Output monitor: logs every PRT event with the cycle it was seen in.
  logic [DW-1:0] mon_data [0:4095];
  int            mon_cyc  [0:4095];
  int            mon_nbytes = 0, mon_nstart = 0, mon_nstop = 0;
  int            mon_start_cyc = 0, mon_stop_cyc = 0, mon_stop_len = 0;
  logic          mon_stop_bad = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prt_start_receive) begin
        mon_nstart    <= mon_nstart + 1;
        mon_start_cyc <= cycle_count;
      end
      if (prt_frame_in_valid) begin
        mon_data[mon_nbytes % 4096] <= prt_frame_data_in;
        mon_cyc[mon_nbytes % 4096]  <= cycle_count;
        mon_nbytes                  <= mon_nbytes + 1;
      end
      if (prt_stop_receive) begin
        mon_nstop    <= mon_nstop + 1;
        mon_stop_cyc <= cycle_count;
        mon_stop_len <= int'(prt_frame_len);
        mon_stop_bad <= prt_frame_bad;
      end
    end
  end

  int            n_assert = 0, n_fail = 0;
  int            exp_acc = 0, exp_drop = 0;
  logic [DW-1:0] drv_data [0:2047];
  int            drv_cyc  [0:2047];
  int            sof_c, eof_c;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
    repeat (n) step();
  endtask

  // Drives the first n_drive bytes of a len-byte frame; byte i = base + inc*i.
  task automatic send_frame(input int len, input bit slot, input int err_idx, input int gap_pct,
                            input logic [7:0] base, input logic [7:0] inc, input int n_drive);
    int gaps;
    prt_slot_available = slot;
    for (int i = 0; i < n_drive; i++) begin
      gaps = 0;
      while (i > 0 && gaps < 3 && $urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
        rx_data  = 8'($urandom);
        gaps++;
        step();
      end
      drv_data[i] = 8'(base + inc * i);
      drv_cyc[i]  = cycle_count;
      if (i == 0) sof_c = cycle_count;
      if (i == len - 1) eof_c = cycle_count;
      rx_valid = 1'b1;
      rx_data  = drv_data[i];
      rx_sof   = (i == 0);
      rx_eof   = (i == len - 1);
      rx_err   = (i == err_idx);
      step();
      if (i == 0) prt_slot_available = 1'($urandom_range(1));
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
  endtask

  // Reference model: a frame is opened only with a free slot and more than one byte;
  // at most MAXF bytes reach the PRT; bad = error, runt or oversize.
  task automatic run_frame(input string tag, input int len, input bit slot, input int err_idx,
                           input int gap_pct, input logic [7:0] base, input logic [7:0] inc);
    int  b0, s0, p0, nexp, mism;
    bit  opened, bad;
    b0 = mon_nbytes; s0 = mon_nstart; p0 = mon_nstop;
    send_frame(len, slot, err_idx, gap_pct, base, inc, len);
    idle(20);
    opened = slot && (len > 1);
    nexp   = opened ? ((len > MAXF) ? MAXF : len) : 0;
    bad    = (err_idx >= 0 && err_idx < len) || (len < MINF) || (len > MAXF);
    if (opened && !bad) exp_acc++;
    else exp_drop++;
    check($sformatf("%s.starts", tag), mon_nstart - s0, int'(opened));
    check($sformatf("%s.bytes", tag), mon_nbytes - b0, nexp);
    check($sformatf("%s.stops", tag), mon_nstop - p0, int'(opened));
    mism = 0;
    for (int k = 0; k < nexp; k++) begin
      if (mon_data[(b0 + k) % 4096] !== drv_data[k] || mon_cyc[(b0 + k) % 4096] != drv_cyc[k] + 2)
        mism++;
    end
    check($sformatf("%s.byte_mismatches", tag), mism, 0);
    if (opened) begin
      check($sformatf("%s.start_cycle", tag), mon_start_cyc, sof_c + 1);
      check($sformatf("%s.stop_cycle", tag), mon_stop_cyc, eof_c + 3);
      check($sformatf("%s.len", tag), mon_stop_len, nexp);
      check($sformatf("%s.bad", tag), int'(mon_stop_bad), int'(bad));
    end
    check($sformatf("%s.accepted", tag), int'(frames_accepted), exp_acc % (1 << CW));
    check($sformatf("%s.dropped", tag), int'(frames_dropped), exp_drop % (1 << CW));
    $display("frame %s len=%0d slot=%0d err=%0d -> bytes=%0d accepted=%0d dropped=%0d",
             tag, len, slot, err_idx, mon_nbytes - b0, frames_accepted, frames_dropped);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".start"}, int'(prt_start_receive), 0);
    check({tag, ".fiv"}, int'(prt_frame_in_valid), 0);
    check({tag, ".stop"}, int'(prt_stop_receive), 0);
    check({tag, ".bad"}, int'(prt_frame_bad), 0);
    check({tag, ".len"}, int'(prt_frame_len), 0);
    check({tag, ".accepted"}, int'(frames_accepted), 0);
    check({tag, ".dropped"}, int'(frames_dropped), 0);
  endtask

  initial begin
    int len, err_idx, s0, p0;
    bit slot;
    rst = 1'b1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; rx_data = '0;
    prt_slot_available = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    idle(3);

    run_frame("t1_basic64", 64, 1'b1, -1, 0, 8'h00, 8'h01);
    run_frame("t2_noslot", 64, 1'b0, -1, 0, 8'h10, 8'h01);
    run_frame("t2_next", 64, 1'b1, -1, 0, 8'h20, 8'h03);
    run_frame("t3_runt5", 5, 1'b1, -1, 0, 8'hAA, 8'h11);
    run_frame("one_byte", 1, 1'b1, -1, 0, 8'h55, 8'h00);
    run_frame("t4_oversize", 1519, 1'b1, -1, 0, 8'h07, 8'h01);
    run_frame("t4_next", 70, 1'b1, -1, 0, 8'h40, 8'h05);
    run_frame("max_exact", 1518, 1'b1, -1, 5, 8'h01, 8'h01);
    run_frame("t5_err_gaps", 100, 1'b1, 9, 30, 8'h33, 8'h07);
    run_frame("min_exact", 64, 1'b1, -1, 20, 8'h90, 8'h01);
    run_frame("runt63", 63, 1'b1, -1, 20, 8'h91, 8'h01);

    for (int f = 0; f < 14; f++) begin
      len     = ($urandom_range(3) == 0) ? int'($urandom_range(1, 63)) : int'($urandom_range(64, 200));
      slot    = ($urandom_range(3) != 0);
      err_idx = ($urandom_range(4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_frame($sformatf("rand%0d", f), len, slot, err_idx, 15,
                8'($urandom), 8'($urandom_range(1, 255)));
    end

    // Reset in the middle of a frame: outputs clear at once, no stop pulse.
    s0 = mon_nstart; p0 = mon_nstop;
    send_frame(80, 1'b1, -1, 0, 8'h60, 8'h01, 20);
    rx_valid = 1'b1; rx_data = 8'h74;
    rst = 1'b1;
    #1;
    check_all_zero("t6_midreset");
    idle(3);
    rst = 1'b0;
    idle(5);
    check("t6.starts", mon_nstart - s0, 1);
    check("t6.no_stop", mon_nstop - p0, 0);
    exp_acc = 0; exp_drop = 0;
    run_frame("t6_after_reset", 64, 1'b1, -1, 0, 8'hC0, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
